// File: rtl/soft_processor_pio_pkg.sv
// Shared definitions for the soft-processor PIO blocks: register word addresses
// and the edge-type encoding used by the input PIO.
package soft_processor_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, one-cycle delayed copy and per-bit edge pulse generation,
// with a post-reset warm-up window that suppresses edges while the chain fills.
module pio_sync_edge
    import soft_processor_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned CNT_W       = $clog2(WARM_CYCLES + 1);
    localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARM_CYCLES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [CNT_W-1:0]                  warm_q;
    logic                              warm_done;
    logic [WIDTH-1:0]                  raw_edge;

    assign sync      = stage_q[SYNC_STAGES-1];
    assign warm_done = (warm_q == WARM_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], in_port};
            prev_q  <= sync;
            if (!warm_done) begin
                warm_q <= warm_q + 1'b1;
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: raw_edge = sync & ~prev_q;
            EDGE_FALL: raw_edge = ~sync & prev_q;
            default:   raw_edge = sync ^ prev_q;
        endcase
        // Levels held through reset look like edges until prev has caught up.
        edge_pulse = warm_done ? raw_edge : '0;
    end

endmodule

// File: rtl/soft_processor_pio_in.sv
// Avalon-MM input PIO: DATA, IRQMASK and write-1-to-clear EDGECAP registers.
// Define SOFT_PROCESSOR_PIO_IN_IRQ_EN to implement IRQMASK and the irq output.
module soft_processor_pio_in
    import soft_processor_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_clr;
    logic [WIDTH-1:0] irqmask;

    assign wr_en = chipselect && !write_n;
    assign wdata = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_wdata_unused
        logic unused_wdata;
        assign unused_wdata = ^writedata[31:WIDTH];
    end

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .sync       (sync),
        .edge_pulse (edge_pulse)
    );

    assign edgecap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

    // A new edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecap_q <= '0;
        end else begin
            edgecap_q <= (edgecap_q & ~edgecap_clr) | edge_pulse;
        end
    end

`ifdef SOFT_PROCESSOR_PIO_IN_IRQ_EN
    logic [WIDTH-1:0] irqmask_q;
    logic             irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask_q <= wdata;
            end
            irq_q <= |(edgecap_q & irqmask_q);
        end
    end

    assign irqmask = irqmask_q;
    assign irq     = irq_q;
`else
    assign irqmask = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = sync;
            ADDR_RSVD:    readdata = '0;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soft_processor_pio_in.sv
// Directed bench for soft_processor_pio_in: a rising-edge and an any-edge instance
// share the bus; each has its own input port.
module tb_soft_processor_pio_in;
    import soft_processor_pio_pkg::*;

`ifdef SOFT_PROCESSOR_PIO_IN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_rise;
    logic [7:0]  in_any;
    logic [31:0] rd_rise;
    logic [31:0] rd_any;
    logic        irq_rise;
    logic        irq_any;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rr;
    logic [31:0] ra;

    always #5 clk = ~clk;

    soft_processor_pio_in #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (EDGE_RISE)
    ) u_rise (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_rise),
        .readdata   (rd_rise),
        .irq        (irq_rise)
    );

    soft_processor_pio_in #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (EDGE_ANY)
    ) u_any (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_any),
        .readdata   (rd_any),
        .irq        (irq_any)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r_rise, output logic [31:0] r_any);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        r_rise     = rd_rise;
        r_any      = rd_any;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset      = 1'b1;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_rise    = 8'hFF;
        in_any     = 8'hFF;

        // Reset with inputs held high, then release: no spurious capture.
        ticks(3);
        rd(ADDR_DATA, rr, ra);
        check_eq("reset_data", rr, 32'h0);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("reset_edgecap", rr, 32'h0);
        check_eq("reset_irq", {31'b0, irq_rise}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("warmup_irq", {31'b0, irq_rise}, 32'h0);
        end
        rd(ADDR_DATA, rr, ra);
        check_eq("warm_data_rise", rr, 32'hFF);
        check_eq("warm_data_any", ra, 32'hFF);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("warm_cap_rise", rr, 32'h0);
        check_eq("warm_cap_any", ra, 32'h0);

        // Falling edges: captured by the any-edge instance only.
        in_rise = 8'h00;
        in_any  = 8'h00;
        ticks(5);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("fall_cap_rise", rr, 32'h0);
        check_eq("fall_cap_any", ra, 32'hFF);
        wr(ADDR_IRQMASK, 32'h04);
        rd(ADDR_IRQMASK, rr, ra);
        check_eq("irqmask_rb", rr, IRQ_EN ? 32'h04 : 32'h0);
        wr(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("clr_all_any", ra, 32'h0);

        // Rising 00 -> 05, k is the next edge.
        in_rise = 8'h05;
        ticks(2);
        rd(ADDR_DATA, rr, ra);
        check_eq("rise_data_k1", rr, 32'h05);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("rise_cap_k1", rr, 32'h0);
        tick();
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("rise_cap_k2", rr, 32'h05);
        check_eq("rise_irq_k2", {31'b0, irq_rise}, 32'h0);
        tick();
        check_eq("rise_irq_k3", {31'b0, irq_rise}, {31'b0, IRQ_EN});

        // Partial clear keeps irq; clearing the masked bit drops irq a cycle later.
        wr(ADDR_EDGECAP, 32'h01);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("clr1_cap", rr, 32'h04);
        check_eq("clr1_irq_w", {31'b0, irq_rise}, {31'b0, IRQ_EN});
        tick();
        check_eq("clr1_irq_w1", {31'b0, irq_rise}, {31'b0, IRQ_EN});
        wr(ADDR_EDGECAP, 32'h04);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("clr4_cap", rr, 32'h0);
        check_eq("clr4_irq_w", {31'b0, irq_rise}, {31'b0, IRQ_EN});
        tick();
        check_eq("clr4_irq_w1", {31'b0, irq_rise}, 32'h0);

        // Clear colliding with a new edge on bit 0: the edge wins.
        in_rise = 8'h04;
        ticks(4);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("fall_ignored_rise", rr, 32'h0);
        in_rise = 8'h05;
        ticks(2);
        wr(ADDR_EDGECAP, 32'h01);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("set_wins", rr, 32'h01);
        wr(ADDR_DATA, 32'hFF);
        rd(ADDR_DATA, rr, ra);
        check_eq("data_ro", rr, 32'h05);
        rd(ADDR_RSVD, rr, ra);
        check_eq("rsvd_rise", rr, 32'h0);
        check_eq("rsvd_any", ra, 32'h0);

        // Any-edge: bit 7 captured on both transitions, 5 cycles apart.
        in_any = 8'h80;
        ticks(3);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("any_up", ra, 32'h80);
        wr(ADDR_EDGECAP, 32'h80);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("any_up_clr", ra, 32'h0);
        tick();
        in_any = 8'h00;
        ticks(3);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("any_down", ra, 32'h80);
        wr(ADDR_EDGECAP, 32'h80);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("any_down_clr", ra, 32'h0);

        // One-cycle glitch on bit 3 stays latched until cleared.
        in_any = 8'h08;
        tick();
        in_any = 8'h00;
        ticks(5);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("glitch_latched", ra, 32'h08);
        wr(ADDR_EDGECAP, 32'h08);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("glitch_clr", ra, 32'h0);

        // Fill EDGECAP with FF, raise irq, then a 1-cycle reset wipes everything.
        in_rise = 8'h00;
        ticks(4);
        in_rise = 8'hFF;
        ticks(4);
        wr(ADDR_IRQMASK, 32'hFF);
        tick();
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("pre_rst_cap", rr, 32'hFF);
        check_eq("pre_rst_irq", {31'b0, irq_rise}, {31'b0, IRQ_EN});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_irq", {31'b0, irq_rise}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rr, ra);
            check_eq("mid_rst_reg", rr, 32'h0);
        end
        tick();
        check_eq("mid_rst_irq_1", {31'b0, irq_rise}, 32'h0);
        ticks(6);
        rd(ADDR_EDGECAP, rr, ra);
        check_eq("post_rst_cap", rr, 32'h0);
        rd(ADDR_DATA, rr, ra);
        check_eq("post_rst_data", rr, 32'hFF);
        wr(ADDR_IRQMASK, 32'hFF);
        rd(ADDR_IRQMASK, rr, ra);
        check_eq("irqmask_ff", rr, IRQ_EN ? 32'hFF : 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soft_processor_pio_in.md
# soft_processor_pio_in

Avalon-MM slave input PIO for the soft-processor subsystem, the counterpart of the output PIO. It synchronises an external WIDTH-bit input bus into the `clk` domain and exposes the level on a data register. It latches selected edges into a write-1-to-clear edge-capture register and raises a maskable level interrupt to the Nios-class CPU. It sits on the same system interconnect as the output PIO, with the same 2-bit word address and zero-wait-state read.

## Interface
- WIDTH, 8, width of `in_port` and of the data, mask and capture registers (1..32)
- SYNC_STAGES, 2, flip-flop synchroniser depth on `in_port` (2..4)
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by `chipselect`
- writedata  in  32  write data; bits above WIDTH ignored
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  read data, combinational from registers, upper bits zero
- irq  out  1  level interrupt, registered

## Operation
- Register map:
  - 0 DATA: read-only, synchronised level; writes ignored
  - 1 reserved: reads 0, writes ignored
  - 2 IRQMASK: read/write, WIDTH bits
  - 3 EDGECAP: read; a write clears each bit where `writedata` is 1
- Write strobe is `chipselect && !write_n`. Reads have no side effects.
- Synchroniser output `sync` feeds `prev`, a 1-cycle delayed copy.
- Edge detection per bit:
  - rising: `sync & ~prev`
  - falling: `~sync & prev`
  - any: `sync ^ prev`
- Warm-up counter:
  - After reset, a counter runs SYNC_STAGES+1 cycles. Edge detection is forced to 0 until it saturates.
  - An input held high through reset therefore never produces a spurious capture.
- EDGECAP bit update each cycle: set if an edge is detected; else cleared if written with 1; else held.
- Set wins over clear when both occur in the same cycle on the same bit.
- `irq` is registered: `|(EDGECAP & IRQMASK)` from the previous cycle.
- Reset values: all sync stages, `prev`, IRQMASK, EDGECAP and `irq` are 0. The warm-up counter is 0.
- `readdata` is 0 whenever no register holds a set bit. No internal reset state is visible other than zeros.
- Reset asserted mid-operation clears all state within one cycle. Pending captures are lost and `irq` drops on the following edge.

## Timing
- Let `in_port` change before rising edge k.
  - DATA reflects the new level after edge k+SYNC_STAGES-1.
  - The EDGECAP bit is set after edge k+SYNC_STAGES.
  - `irq` rises after edge k+SYNC_STAGES+1 if the bit is masked in.
- EDGECAP clear write at edge w: the bit reads 0 after w and `irq` falls after w+1, unless a new edge arrives.
- IRQMASK write at edge w affects `irq` after w+1.
- Read is zero-wait-state. `readdata` is valid in the same cycle as `address` and reflects register state after the last clock edge.
- Input pulses shorter than one `clk` period may be missed. The minimum guaranteed-captured pulse is 2 cycles.

## Configuration
- Macro `SOFT_PROCESSOR_PIO_IN_IRQ_EN`.
- Defined: IRQMASK is implemented and `irq` behaves as above.
- Undefined:
  - IRQMASK reads 0 and writes are ignored.
  - `irq` is tied to 0 and its register is removed.
  - EDGECAP remains fully functional for polled use.

## Structure
- Shared package `soft_processor_pio_pkg` holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_TYPE encoding constants EDGE_RISE, EDGE_FALL, EDGE_ANY
- One sub-module, `pio_sync_edge`, contains:
  - the SYNC_STAGES synchroniser, the `prev` register and the warm-up counter
  - per-bit edge pulse generation
- Outputs of `pio_sync_edge`: `sync` and `edge` vectors.

## Test plan
- Reset with `in_port`=8'hFF held, then release for 10 cycles. Expect DATA reads 8'hFF and EDGECAP reads 0, with `irq` 0 throughout.
- EDGE_TYPE=0, drive `in_port` 8'h00→8'h05 for 3 cycles. EDGECAP must read 8'h05 after edge k+2; DATA must read 8'h05; with IRQMASK=8'h04, `irq`=1 after edge k+3.
- Write 8'h01 to EDGECAP. EDGECAP must read 8'h04 and `irq` stays 1. Then write 8'h04: EDGECAP reads 0 and `irq` falls one cycle later.
- Issue a clear write to bit 0 in the same cycle bit 0's edge pulse fires. Bit 0 must remain 1.
- EDGE_TYPE=2, toggle bit 7 high then low 5 cycles apart, clearing in between. Bit 7 must be captured on both transitions; a 1-cycle glitch on bit 3 with no clear must remain latched until cleared.
- Assert `reset` for 1 cycle while `irq`=1 and EDGECAP=8'hFF. All registers must read 0 and `irq` must be 0 within one cycle after release. Without `SOFT_PROCESSOR_PIO_IN_IRQ_EN`, a write of 8'hFF to IRQMASK must read back 0.
